// File: rtl/window_fill_ctrl_pkg.sv
// Shared types and helpers for the window write-side controller.
// Default-geometry sizes live here; parametric widths come from the helper functions.
package window_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFillFull,
        StFillCol,
        StHold
    } fill_state_e;

    localparam int unsigned DEF_KERNEL_DIM  = 3;
    localparam int unsigned WINDOW_REG_SIZE = DEF_KERNEL_DIM * DEF_KERNEL_DIM;
    localparam int unsigned COL_W           = $clog2(DEF_KERNEL_DIM);

    // Counter width for a modulo-m counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic bit addr_fits(input int unsigned k, input int unsigned aw);
        return (64'(1) << aw) >= 64'(k * k);
    endfunction

endpackage

// File: rtl/window_fill_ctrl_if.sv
// Element stream in and window-register write port out.
// The controller takes the slave view; the source/register side takes the master view.
interface window_fill_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/window_fill_ctrl_modk_counter.sv
// Modulo-MOD up counter with clear/load; wrap flags the increment from MOD-1 back to 0.
module modk_counter
    import window_fill_ctrl_pkg::*;
#(
    parameter int unsigned MOD = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic [cnt_width(MOD)-1:0] load_val,
    input  logic                      inc,
    output logic [cnt_width(MOD)-1:0] count,
    output logic                      wrap
);
    localparam int unsigned W = cnt_width(MOD);
    localparam logic [W-1:0] Last = W'(MOD - 1);

    logic [W-1:0] count_q;

    assign count = count_q;
    assign wrap  = inc && (count_q == Last);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (inc) begin
            count_q <= wrap ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/window_fill_ctrl.sv
// Write-side controller for the KxK window register: full column-major fills or
// single-column sliding refills, holding each complete window until acknowledged.
module window_fill_ctrl
    import window_fill_ctrl_pkg::*;
#(
    parameter int unsigned WINDOW_ELEMNT_SIZE = 8,
    parameter int unsigned KERNEL_DIM         = 3,
    parameter int unsigned ADDR_SIZE          = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic                             i_slide,
    input  logic                             i_win_ack,
    window_fill_ctrl_if.slave                bus,
    output logic                             o_win_valid,
    output logic [cnt_width(KERNEL_DIM)-1:0] o_col_base,
    output logic                             o_busy
);
    localparam int unsigned ColW = cnt_width(KERNEL_DIM);
    localparam logic [ColW-1:0] LastCol = ColW'(KERNEL_DIM - 1);

    if (!addr_fits(KERNEL_DIM, ADDR_SIZE)) begin : g_addr_chk
        $error("ADDR_SIZE too small for KERNEL_DIM*KERNEL_DIM window");
    end

    fill_state_e     state_q, state_d;
    logic            win_valid_q, win_valid_d;
    logic [ColW-1:0] col_base_q, col_base_d;

    logic [ColW-1:0] row, col;
    logic            row_wrap, col_wrap;
    logic            row_clear, col_clear, col_load, col_inc;
    logic            xfer;

    assign bus.s_ready = (state_q == StFillFull) || (state_q == StFillCol);
    assign xfer        = bus.s_valid && bus.s_ready;
    assign bus.wr_en   = xfer;
    assign bus.wr_data = bus.s_data;
    assign bus.wr_addr = ADDR_SIZE'(row) * ADDR_SIZE'(KERNEL_DIM) + ADDR_SIZE'(col);

    // Column only advances during a full fill; a sliding refill stays on o_col_base.
    assign col_inc = row_wrap && (state_q == StFillFull);

    modk_counter #(.MOD(KERNEL_DIM)) u_row_cnt (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (row_clear),
        .load     (1'b0),
        .load_val ('0),
        .inc      (xfer),
        .count    (row),
        .wrap     (row_wrap)
    );

    modk_counter #(.MOD(KERNEL_DIM)) u_col_cnt (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (col_clear),
        .load     (col_load),
        .load_val (col_base_q),
        .inc      (col_inc),
        .count    (col),
        .wrap     (col_wrap)
    );

    always_comb begin
        state_d     = state_q;
        win_valid_d = win_valid_q;
        col_base_d  = col_base_q;
        row_clear   = 1'b0;
        col_clear   = 1'b0;
        col_load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StFillFull;
                    row_clear = 1'b1;
                    col_clear = 1'b1;
                end
            end
            StFillFull: begin
                if (col_wrap) begin
                    state_d     = StHold;
                    col_base_d  = '0;
                    win_valid_d = 1'b1;
                end
            end
            StFillCol: begin
                if (row_wrap) begin
                    state_d     = StHold;
                    col_base_d  = (col_base_q == LastCol) ? '0 : col_base_q + 1'b1;
                    win_valid_d = 1'b1;
                end
            end
            StHold: begin
                if (i_win_ack) begin
                    win_valid_d = 1'b0;
                    row_clear   = 1'b1;
                    if (i_slide) begin
                        state_d  = StFillCol;
                        col_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            win_valid_q <= 1'b0;
            col_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            col_base_q  <= col_base_d;
        end
    end

    assign o_win_valid = win_valid_q;
    assign o_col_base  = col_base_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_window_fill_ctrl.sv
// Directed bench for window_fill_ctrl (K=3): full fill, stalled fill, slides, hold, reset.
module tb_window_fill_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_slide;
    logic       i_win_ack;
    logic       o_win_valid;
    logic [1:0] o_col_base;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];

    window_fill_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    window_fill_ctrl #(
        .WINDOW_ELEMNT_SIZE (8),
        .KERNEL_DIM         (3),
        .ADDR_SIZE          (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_slide     (i_slide),
        .i_win_ack   (i_win_ack),
        .bus         (bus.slave),
        .o_win_valid (o_win_valid),
        .o_col_base  (o_col_base),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Window register stand-in.
    always @(posedge i_clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] a);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        #1;
        check_eq("push_ready", 32'(bus.s_ready), 32'd1);
        check_eq("push_wr_en", 32'(bus.wr_en), 32'd1);
        check_eq("push_addr", 32'(bus.wr_addr), 32'(a));
        check_eq("push_data", 32'(bus.wr_data), 32'(d));
        cyc();
    endtask

    task automatic check_idle_outputs(input string tag);
        #1;
        check_eq({tag, "_ready"}, 32'(bus.s_ready), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check_eq({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
        check_eq({tag, "_winv"}, 32'(o_win_valid), 32'd0);
        check_eq({tag, "_base"}, 32'(o_col_base), 32'd0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic ack(input logic slide);
        bus.s_valid = 1'b0;
        i_win_ack   = 1'b1;
        i_slide     = slide;
        cyc();
        i_win_ack   = 1'b0;
        i_slide     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] full_addr [9];
        logic [7:0] full_mem  [9];
        logic [3:0] col_addr  [3];
        full_addr = '{4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8};
        full_mem  = '{8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9};

        i_rst = 1'b1; i_start = 1'b0; i_slide = 1'b0; i_win_ack = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        @(negedge i_clk);
        cyc(); cyc();
        check_idle_outputs("reset");
        i_rst = 1'b0;
        cyc();

        // Full fill, no stalls.
        pulse_start();
        #1;
        check_eq("fill_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < 9; i++) begin
            check_eq("fill_winv_pre", 32'(o_win_valid), 32'd0);
            push(8'(i + 1), full_addr[i]);
        end
        #1;
        check_eq("hold_winv", 32'(o_win_valid), 32'd1);
        check_eq("hold_base", 32'(o_col_base), 32'd0);
        check_eq("hold_ready", 32'(bus.s_ready), 32'd0);
        check_eq("hold_wr_en", 32'(bus.wr_en), 32'd0);
        for (int a = 0; a < 9; a++) check_eq("mem_full", 32'(mem[a]), 32'(full_mem[a]));

        // Start during HOLD is ignored.
        pulse_start();
        #1;
        check_eq("hold_start_winv", 32'(o_win_valid), 32'd1);
        check_eq("hold_start_ready", 32'(bus.s_ready), 32'd0);

        // Three slides walk the oldest column around.
        for (int s = 0; s < 3; s++) begin
            ack(1'b1);
            #1;
            check_eq("slide_winv_clr", 32'(o_win_valid), 32'd0);
            col_addr = '{4'(s), 4'(s + 3), 4'(s + 6)};
            for (int r = 0; r < 3; r++) push(8'(10 + 3 * s + r), col_addr[r]);
            #1;
            check_eq("slide_winv", 32'(o_win_valid), 32'd1);
            check_eq("slide_base", 32'(o_col_base), 32'((s + 1) % 3));
        end
        check_eq("mem_slide0", 32'(mem[0]), 32'd10);
        check_eq("mem_slide4", 32'(mem[4]), 32'd14);
        check_eq("mem_slide8", 32'(mem[8]), 32'd18);

        // Ack without slide returns to IDLE.
        ack(1'b0);
        #1;
        check_eq("exit_busy", 32'(o_busy), 32'd0);
        check_eq("exit_winv", 32'(o_win_valid), 32'd0);

        // Stalled fill: s_valid low every other cycle.
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            push(8'(i + 1), full_addr[i]);
            bus.s_valid = 1'b0;
            #1;
            check_eq("stall_wr_en", 32'(bus.wr_en), 32'd0);
            check_eq("stall_winv", 32'(o_win_valid), (i == 8) ? 32'd1 : 32'd0);
            cyc();
        end
        for (int a = 0; a < 9; a++) check_eq("mem_stall", 32'(mem[a]), 32'(full_mem[a]));
        ack(1'b0);

        // Reset mid-fill abandons the partial window.
        pulse_start();
        for (int i = 0; i < 4; i++) push(8'(20 + i), full_addr[i]);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd24;
        i_rst       = 1'b1;
        cyc();
        i_rst = 1'b0;
        check_idle_outputs("midrst");
        bus.s_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            check_eq("refill_winv_pre", 32'(o_win_valid), 32'd0);
            push(8'(20 + i), full_addr[i]);
        end
        #1;
        check_eq("refill_winv", 32'(o_win_valid), 32'd1);
        check_eq("refill_mem0", 32'(mem[0]), 32'd20);
        check_eq("refill_mem8", 32'(mem[8]), 32'd28);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_fill_ctrl.md
Name: window_fill_ctrl

Overview:
Write-side controller for the K×K window register. It accepts a streamed pixel/element source over a valid/ready handshake and generates the window register's write port (wr_en, wr_addr, wr_data). It signals a consumer when a complete window is resident and holds it until the consumer acknowledges. Two refill modes exist: full refill of all K*K elements, or sliding refill of one new column that overwrites the oldest column.

Parameters:
WINDOW_ELEMNT_SIZE, 8, element width in bits
KERNEL_DIM, 3, window edge K; window holds K*K elements, row-major address r*K+c
ADDR_SIZE, 4, window address width; 2^ADDR_SIZE >= KERNEL_DIM*KERNEL_DIM is required (elaboration-time check)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  pulse; begins a full fill when in IDLE, ignored otherwise
i_slide  in  1  sampled with i_win_ack; 1 = slide one column, 0 = return to IDLE
s_valid  in  1  source element valid
s_ready  out  1  controller accepts element
s_data  in  WINDOW_ELEMNT_SIZE  source element
wr_en  out  1  window register write enable
wr_addr  out  ADDR_SIZE  window register write address
wr_data  out  WINDOW_ELEMNT_SIZE  window register write data
o_win_valid  out  1  complete window resident and readable
i_win_ack  in  1  consumer has finished reading the window
o_col_base  out  clog2(KERNEL_DIM)  physical column index of the oldest (logical column 0) data
o_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, FILL_FULL, FILL_COL, HOLD. Reset -> IDLE. Row counter, column pointer, and element count cleared. o_col_base=0, o_win_valid=0, s_ready=0, wr_en=0, wr_addr=0.
- Input order is column-major: for each column, rows 0..K-1 top to bottom.
- Transfer occurs when s_valid && s_ready. wr_en = transfer, combinational in the same cycle. wr_data = s_data (passthrough). wr_addr = row*K + col (combinational from counters). The write lands at the next rising edge.
- s_ready = 1 only in FILL_FULL or FILL_COL. It has no dependency on s_valid.
- IDLE: i_start -> FILL_FULL with row=0, col=0.
- FILL_FULL: on each transfer, row increments. On row wrap (K-1 -> 0), col increments. After K*K transfers -> HOLD. o_col_base is set to 0 and o_win_valid is registered high the cycle after the last write.
- HOLD: o_win_valid=1, no writes. i_win_ack with i_slide=1 -> FILL_COL with col=o_col_base, row=0; o_win_valid clears on the same edge. i_win_ack with i_slide=0 -> IDLE; o_win_valid clears. i_win_ack outside HOLD is ignored.
- FILL_COL: accepts K transfers into physical column o_col_base. After the Kth transfer: o_col_base <= (o_col_base+1) mod K, then -> HOLD with o_win_valid high the next cycle.
- A consumer reading logical column j uses physical column (o_col_base + j) mod K.
- i_start during any non-IDLE state is ignored. s_valid stalls (gaps) pause counters with no writes.
- Reset mid-fill: the partial window is abandoned, all state returns to reset values, and the next i_start restarts at address 0. Window register contents are not cleared; they are stale until refilled.
- Throughput: one element per cycle. Full-window latency = K*K transfers + 1 cycle to o_win_valid.

Decomposition:
- Shared package: state enum (IDLE, FILL_FULL, FILL_COL, HOLD), localparams WINDOW_REG_SIZE = KERNEL_DIM*KERNEL_DIM and COL_W = clog2(KERNEL_DIM), and the address-width check function.
- Sub-module: modk_counter (parameter MOD; ports clk, rst, clear, load, load_val, inc, count, wrap). It is instanced for the row counter and the column pointer.
- The window register itself is instanced by the parent, not inside this block.

Test Plan:
- Full fill, no stalls (K=3): reset, i_start, s_data 1..9 with s_valid held high -> wr_addr sequence 0,3,6,1,4,7,2,5,8 on consecutive cycles. o_win_valid=1 one cycle after the 9th write. o_col_base=0. Window contents read back as 1,4,7,2,5,8,3,6,9 at addresses 0..8.
- Stalls: the same data with s_valid low on every other cycle -> identical address/data pairs, wr_en never high while s_valid is low, o_win_valid after the 9th transfer only.
- Slide sequence: ack+slide with 10,11,12 -> addresses 0,3,6 and o_col_base=1. Next ack+slide with 13,14,15 -> addresses 1,4,7 and o_col_base=2. Next with 16,17,18 -> addresses 2,5,8 and o_col_base=0.
- Hold and exit: s_valid=1 during HOLD -> s_ready=0 and wr_en=0. i_start during HOLD is ignored. Ack with i_slide=0 -> IDLE next cycle with o_busy=0 and o_win_valid=0.
- Reset mid-fill: assert i_rst after 4 transfers -> next cycle all outputs at reset values. A following i_start with data 20.. -> first write to address 0, and o_win_valid only after 9 new transfers.
